// File: rtl/semaforo_multi.sv
// rtl/semaforo_multi.sv - multi-street traffic light controller with demand skipping and night flash
module semaforo_multi #(
    parameter int N_RUAS      = 4,
    parameter int T_VERDE     = 20,
    parameter int T_VERDE_MIN = 8,
    parameter int T_AMARELO   = 4,
    parameter int T_VERMELHO  = 2,
    parameter int T_PISCA     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [N_RUAS-1:0]           pedido,
    input  logic                        modo_noturno,
    output logic [N_RUAS-1:0]           vermelho,
    output logic [N_RUAS-1:0]           amarelo,
    output logic [N_RUAS-1:0]           verde,
    output logic [$clog2(N_RUAS)-1:0]   rua_ativa
);
    localparam int RW    = $clog2(N_RUAS);
    localparam int T_M1  = (T_VERDE > T_AMARELO) ? T_VERDE : T_AMARELO;
    localparam int T_M2  = (T_VERMELHO > T_PISCA) ? T_VERMELHO : T_PISCA;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [1:0] VERDE          = 2'd0;
    localparam logic [1:0] AMARELO        = 2'd1;
    localparam logic [1:0] TODOS_VERMELHO = 2'd2;
    localparam logic [1:0] PISCA          = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [RW-1:0]     rua, rua_nxt, rua_prox;
    logic [N_RUAS-1:0] pending, pending_nxt;
    logic              fase, fase_nxt;
    logic [N_RUAS-1:0] sel;
    logic              outros_pend;
    logic              achou;

    assign sel         = N_RUAS'(1) << rua;
    assign outros_pend = |(pending & ~sel);
    assign rua_ativa   = rua;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= VERDE;
            cnt     <= '0;
            rua     <= '0;
            pending <= '0;
            fase    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rua     <= rua_nxt;
            pending <= pending_nxt;
            fase    <= fase_nxt;
        end
    end

    // Round-robin scan starting after the current street; plain +1 if nobody is waiting
    always_comb begin
        rua_prox = RW'((int'(rua) + 1) % N_RUAS);
        achou    = 1'b0;
        for (int k = 1; k < N_RUAS; k++) begin
            if (!achou && pending[(int'(rua) + k) % N_RUAS]) begin
                rua_prox = RW'((int'(rua) + k) % N_RUAS);
                achou    = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tick ? cnt + CW'(1) : cnt;
        rua_nxt     = rua;
        fase_nxt    = fase;
        pending_nxt = pending | (pedido & ~((state == VERDE) ? sel : '0));
        case (state)
            VERDE: begin
                if (tick && (modo_noturno || cnt == CW'(T_VERDE - 1) ||
                             (outros_pend && cnt >= CW'(T_VERDE_MIN - 1)))) begin
                    state_nxt = AMARELO;
                    cnt_nxt   = '0;
                end
            end
            AMARELO: begin
                if (tick && cnt == CW'(T_AMARELO - 1)) begin
                    state_nxt = TODOS_VERMELHO;
                    cnt_nxt   = '0;
                end
            end
            TODOS_VERMELHO: begin
                if (tick && cnt == CW'(T_VERMELHO - 1)) begin
                    cnt_nxt = '0;
                    if (modo_noturno) begin
                        state_nxt = PISCA;
                        fase_nxt  = 1'b1;
                    end else begin
                        state_nxt             = VERDE;
                        rua_nxt               = rua_prox;
                        pending_nxt[rua_prox] = 1'b0;
                    end
                end
            end
            PISCA: begin
                if (tick) begin
                    if (!modo_noturno) begin
                        state_nxt = TODOS_VERMELHO;
                        cnt_nxt   = '0;
                    end else if (cnt == CW'(T_PISCA - 1)) begin
                        fase_nxt = ~fase;
                        cnt_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = TODOS_VERMELHO;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        vermelho = '0;
        amarelo  = '0;
        verde    = '0;
        case (state)
            VERDE: begin
                verde    = sel;
                vermelho = ~sel;
            end
            AMARELO: begin
                amarelo  = sel;
                vermelho = ~sel;
            end
            PISCA:   amarelo  = fase ? '1 : '0;
            default: vermelho = '1;
        endcase
    end
endmodule

// File: tb/tb_semaforo_multi.sv
// tb/tb_semaforo_multi.sv - directed-vector bench for semaforo_multi
module tb_semaforo_multi;
    localparam int K_G = 0, K_Y = 1, K_R = 2, K_P1 = 3, K_P0 = 4;

    logic       clk, rst, tick, modo_noturno;
    logic [3:0] pedido, vermelho, amarelo, verde;
    logic [1:0] rua_ativa;
    logic [15:0] obs;
    int n_vec = 0;
    int n_err = 0;

    semaforo_multi #(
        .N_RUAS(4), .T_VERDE(5), .T_VERDE_MIN(2),
        .T_AMARELO(2), .T_VERMELHO(1), .T_PISCA(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .pedido(pedido),
        .modo_noturno(modo_noturno), .vermelho(vermelho),
        .amarelo(amarelo), .verde(verde), .rua_ativa(rua_ativa)
    );

    assign obs = {2'b00, rua_ativa, vermelho, amarelo, verde};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_vec(input int kind, input int r);
        logic [3:0]  s;
        logic [11:0] l;
        s = 4'b0001 << r;
        case (kind)
            K_G:     l = {~s, 4'h0, s};
            K_Y:     l = {~s, s, 4'h0};
            K_R:     l = {4'hF, 8'h00};
            K_P1:    l = {4'h0, 4'hF, 4'h0};
            default: l = 12'h000;
        endcase
        return {2'b00, 2'(r), l};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_seq(input string tag, input int kind, input int r, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), obs, exp_vec(kind, r));
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pedido = '0; modo_noturno = 1'b0; tick = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; pedido = '0; modo_noturno = 1'b0;
        @(negedge clk);

        // Free-running rotation with no demand
        do_reset();
        check("reset_lamps", obs, 16'h0E01);
        for (int s = 0; s < 4; s++) begin
            expect_seq($sformatf("rot_g%0d", s), K_G, s, 5);
            expect_seq($sformatf("rot_y%0d", s), K_Y, s, 2);
            expect_seq($sformatf("rot_r%0d", s), K_R, s, 1);
        end
        expect_seq("rot_wrap", K_G, 0, 1);

        // Single request on street 2 skips street 1 and is cleared once served
        do_reset();
        pedido = 4'b0100;
        expect_seq("p2_g0a", K_G, 0, 1);
        pedido = '0;
        expect_seq("p2_g0b", K_G, 0, 1);
        expect_seq("p2_y0", K_Y, 0, 2);
        expect_seq("p2_r0", K_R, 0, 1);
        expect_seq("p2_g2", K_G, 2, 5);
        expect_seq("p2_y2", K_Y, 2, 2);
        expect_seq("p2_r2", K_R, 2, 1);
        expect_seq("p2_g3", K_G, 3, 1);

        // Simultaneous requests on 1 and 3 while street 2 is green
        do_reset();
        pedido = 4'b0100;
        expect_seq("p13_g0a", K_G, 0, 1);
        pedido = '0;
        expect_seq("p13_g0b", K_G, 0, 1);
        expect_seq("p13_y0", K_Y, 0, 2);
        expect_seq("p13_r0", K_R, 0, 1);
        pedido = 4'b1010;
        expect_seq("p13_g2a", K_G, 2, 1);
        pedido = '0;
        expect_seq("p13_g2b", K_G, 2, 1);
        expect_seq("p13_y2", K_Y, 2, 2);
        expect_seq("p13_r2", K_R, 2, 1);
        expect_seq("p13_g3", K_G, 3, 2);
        expect_seq("p13_y3", K_Y, 3, 2);
        expect_seq("p13_r3", K_R, 3, 1);
        expect_seq("p13_g1", K_G, 1, 5);
        expect_seq("p13_y1", K_Y, 1, 2);

        // Night mode entry, flashing, and exit
        do_reset();
        modo_noturno = 1'b1;
        expect_seq("nt_g0", K_G, 0, 1);
        expect_seq("nt_y0", K_Y, 0, 2);
        expect_seq("nt_r0", K_R, 0, 1);
        for (int i = 0; i < 2; i++) begin
            expect_seq("nt_on", K_P1, 0, 1);
            expect_seq("nt_off", K_P0, 0, 1);
        end
        modo_noturno = 1'b0;
        expect_seq("nt_last", K_P1, 0, 1);
        expect_seq("nt_rx", K_R, 0, 1);
        expect_seq("nt_g1", K_G, 1, 2);

        // Reset during yellow of street 3 with street 1 pending
        do_reset();
        for (int s = 0; s < 3; s++) begin
            expect_seq($sformatf("rs_g%0d", s), K_G, s, 5);
            expect_seq($sformatf("rs_y%0d", s), K_Y, s, 2);
            expect_seq($sformatf("rs_r%0d", s), K_R, s, 1);
        end
        pedido = 4'b0010;
        expect_seq("rs_g3a", K_G, 3, 1);
        pedido = '0;
        expect_seq("rs_g3b", K_G, 3, 1);
        expect_seq("rs_y3", K_Y, 3, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_seq("rs_after_g0", K_G, 0, 5);
        expect_seq("rs_after_y0", K_Y, 0, 1);

        // Time base stalled: everything frozen, request kept for later
        do_reset();
        tick = 1'b0;
        for (int i = 0; i < 50; i++) begin
            pedido = (i == 10) ? 4'b0100 : 4'b0000;
            check($sformatf("frz[%0d]", i), obs, exp_vec(K_G, 0));
            step();
        end
        pedido = '0;
        tick = 1'b1;
        expect_seq("frz_g0", K_G, 0, 2);
        expect_seq("frz_y0", K_Y, 0, 2);
        expect_seq("frz_r0", K_R, 0, 1);
        expect_seq("frz_g2", K_G, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
